// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampling UART receiver; UART_RX_FIFO_EN selects FIFO buffer over holding register
module uart_rx_os #(
   parameter int CLK_FRE     = 50,
   parameter int BAUD_RATE   = 115200,
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_ON   = 0,
   parameter int PARITY_TYPE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst_n,
   input  logic                  i_uart_rx,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_parity_err,
   output logic                  o_frame_err,
   output logic                  o_overrun,
   output logic                  o_busy
);
   localparam int DIV = (CLK_FRE * 1000000) / (BAUD_RATE * 16);
   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BCW = $clog2(DATA_WIDTH);
   localparam int EW  = DATA_WIDTH + 2;

   if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || STOP_BITS < 1 || STOP_BITS > 2 || DIV < 1 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_rx_os: illegal parameter combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                state_q, state_d;
   logic                  rx_s1_q, rx_s2_q, rx_prev_q;
   logic [DCW-1:0]        div_q, div_d;
   logic [3:0]            tick_cnt_q, tick_cnt_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [1:0]            samp_q, samp_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  perr_q, perr_d, ferr_q, ferr_d, push_q, push_d;
   logic                  overrun_q;
   logic                  tick, vote, fall, pop, full, wr_en;
   logic [EW-1:0]         word;

   assign tick = (state_q != S_IDLE) && (div_q == DCW'(DIV - 1));
   // 2-of-3 vote: ticks 7 and 8 were captured, tick 9 is the live synced line
   assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s2_q) | (samp_q[0] & rx_s2_q);
   assign fall = rx_prev_q & ~rx_s2_q;
   assign word = {ferr_q, perr_q, shift_q};
   assign pop  = o_valid & i_ready;
   assign wr_en = push_q & (~full | pop);
   assign o_busy = (state_q != S_IDLE);
   assign o_overrun = overrun_q;

   // Double-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= i_uart_rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // Receiver state, oversampling counters and frame capture registers
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         samp_q     <= '0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         push_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         push_q     <= push_d;
      end
   end

   // Next-state logic: bit sampling at ticks 7..9, bit advance at tick 15
   always_comb begin
      state_d    = state_q;
      div_d      = (state_q == S_IDLE || tick) ? '0 : div_q + DCW'(1);
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      push_d     = 1'b0;
      if (tick) begin
         tick_cnt_d = tick_cnt_q + 4'd1;
         if (tick_cnt_q == 4'd7) samp_d[0] = rx_s2_q;
         if (tick_cnt_q == 4'd8) samp_d[1] = rx_s2_q;
      end
      case (state_q)
         S_IDLE: begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (fall) begin
               state_d = S_START;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         S_START: begin
            if (tick && tick_cnt_q == 4'd9 && vote) state_d = S_IDLE;
            else if (tick && tick_cnt_q == 4'd15) state_d = S_DATA;
         end
         S_DATA: begin
            if (tick && tick_cnt_q == 4'd9) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
            if (tick && tick_cnt_q == 4'd15) begin
               if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_ON != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick && tick_cnt_q == 4'd9) perr_d = (^shift_q) ^ vote ^ (PARITY_TYPE != 0);
            if (tick && tick_cnt_q == 4'd15) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick && tick_cnt_q == 4'd9) begin
               ferr_d = ferr_q | ~vote;
               if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  push_d  = 1'b1;
               end
            end
            if (tick && tick_cnt_q == 4'd15) bit_cnt_d = bit_cnt_q + BCW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Overrun pulses when a completed frame finds the buffer full with no pop
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) overrun_q <= 1'b0;
      else          overrun_q <= push_q & full & ~pop;
   end

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;

   assign full    = (cnt_q == (AW + 1)'(FIFO_DEPTH));
   assign o_valid = (cnt_q != '0);
   assign {o_frame_err, o_parity_err, o_data} = mem_q[rd_q];

   // Circular receive FIFO with wrap-around pointers and occupancy count
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_q] <= word;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop) rd_q <= rd_q + AW'(1);
         case ({wr_en, pop})
            2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
`else
   logic [EW-1:0] hold_q;
   logic          hold_valid_q;

   assign full    = hold_valid_q;
   assign o_valid = hold_valid_q;
   assign {o_frame_err, o_parity_err, o_data} = hold_q;

   // Single holding register; a push with a simultaneous pop replaces the entry
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else if (wr_en) begin
         hold_q       <= word;
         hold_valid_q <= 1'b1;
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter CLK_FRE, default 50, system clock frequency in MHz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 Parameter DATA_WIDTH, default 8, data bits per frame; legal 5..9.
REQ-004 Parameter PARITY_ON, default 0; 1 = one parity bit after the data bits.
REQ-005 Parameter PARITY_TYPE, default 0; 0 = even, 1 = odd.
REQ-006 Parameter STOP_BITS, default 1; legal 1 or 2.
REQ-007 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, at least 2; used only with UART_RX_FIFO_EN.
REQ-008 i_clk_sys  input  1  system clock; all logic on rising edge.
REQ-009 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-010 i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-011 o_data  output  DATA_WIDTH  received word at the head of the buffer.
REQ-012 o_valid  output  1  head entry is valid.
REQ-013 i_ready  input  1  consumer accepts the head entry.
REQ-014 o_parity_err  output  1  parity error flag of the head entry; 0 when PARITY_ON=0.
REQ-015 o_frame_err  output  1  stop-bit error flag of the head entry.
REQ-016 o_overrun  output  1  one-cycle pulse: completed frame dropped, buffer full.
REQ-017 o_busy  output  1  high in every state except IDLE.

Function
REQ-018 i_uart_rx SHALL pass through a 2-flop synchronizer; both flops set to 1 at reset.
REQ-019 Tick generator SHALL pulse once every DIV = CLK_FRE*1000000/(BAUD_RATE*16) clocks (integer division); the divider is held at 0 in IDLE.
REQ-020 Each bit period SHALL be 16 ticks, numbered 0..15; a bit value SHALL be the 2-of-3 majority of the synced line at ticks 7, 8 and 9.
REQ-021 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-022 IDLE->START SHALL occur on a falling edge of the synced line.
REQ-023 START SHALL return to IDLE with no output if the start-bit majority is 1 (false start); otherwise it goes to DATA at tick 15.
REQ-024 DATA SHALL shift in DATA_WIDTH bits LSB first, then go to PARITY when PARITY_ON=1, else to STOP.
REQ-025 Parity error SHALL be set when XOR(data bits, parity bit) differs from PARITY_TYPE.
REQ-026 STOP SHALL sample STOP_BITS bits; frame error SHALL be set if any stop-bit majority is 0.
REQ-027 After the final stop-bit vote (tick 9), the state SHALL return to IDLE, so a start edge from tick 10 onward is detected.
REQ-028 The word and both error flags SHALL be pushed one clock after the final stop-bit vote; o_valid SHALL rise on the next clock if the buffer was empty.
REQ-029 A frame with errors SHALL still be pushed, with its flags set.
REQ-030 An entry SHALL pop when o_valid and i_ready are both high; o_data, o_parity_err and o_frame_err SHALL stay stable while o_valid is high and i_ready is low.
REQ-031 If the buffer is full and a push coincides with a pop, both SHALL occur with no overrun.
REQ-032 If the buffer is full and a push has no coinciding pop, the new word SHALL be dropped, buffer contents SHALL be unchanged, and o_overrun SHALL pulse for one clock.

Reset
REQ-033 Reset SHALL set the state to IDLE and clear the tick, bit and shift counters and the buffer.
REQ-034 Reset SHALL drive o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0 and o_busy=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no push; reception SHALL restart on the first falling edge after release.

Configuration
REQ-036 With macro UART_RX_FIFO_EN defined, the buffer SHALL be a FIFO of FIFO_DEPTH entries, each holding {frame_err, parity_err, data}, with wrap-around pointers.
REQ-037 With UART_RX_FIFO_EN undefined, the buffer SHALL be a single holding register (depth 1) and FIFO_DEPTH SHALL be ignored; all other behaviour SHALL be identical.

Verification (CLK_FRE=50, BAUD_RATE=115200, so DIV=27)
REQ-038 Case 1: 8N1 frame 0xA5 with i_ready=1 -> o_data=0xA5, o_valid high for 1 clock, both error flags 0.
REQ-039 Case 2: PARITY_ON=1, even parity, 0x03 sent with parity bit 1 -> o_parity_err=1 and o_data=0x03.
REQ-040 Case 3: 0x55 sent with stop bit 0 -> o_frame_err=1; the next frame 0x12 received clean.
REQ-041 Case 4: line low for 3 ticks then high -> no push and o_busy back to 0 by tick 10 of the start bit.
REQ-042 Case 5: i_ready=0, frames 0x01..0x05, FIFO_DEPTH=4 with macro -> o_overrun pulses once, then pops yield 0x01..0x04; without macro -> o_overrun pulses 4 times, then a pop yields 0x01.
REQ-043 Case 6: reset asserted at data bit 4 of 0xFF -> no push; the following frame 0x3C is received correctly.
